// File: rtl/abp_pkg.sv
// Shared definitions for the Alternating Bit Protocol sender and receiver.
package abp_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2
    } abp_tx_state_t;

    // Packet layout: 8 payload bytes (little-endian) followed by one header byte.
    localparam int unsigned ABP_PKT_BYTES   = 9;
    localparam int unsigned ABP_HDR_IDX     = 8;
    localparam int unsigned ABP_SEQ_BIT_POS = 0;
    localparam int unsigned ABP_IDX_W       = 4;

    // Header byte carrying the sequence bit; all other bits are zero.
    function automatic logic [7:0] abp_hdr_byte(input logic seq);
        logic [7:0] b;
        b = 8'h00;
        b[ABP_SEQ_BIT_POS] = seq;
        return b;
    endfunction

endpackage

// File: rtl/abp_tx_serializer.sv
// Holds the payload and sequence bit of the packet in flight and walks the
// byte index on stream handshakes. load captures a new packet, restart rewinds
// to byte 0 for a retransmission of the same packet.
module abp_tx_serializer
    import abp_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        i_load,
    input  logic [63:0] i_value,
    input  logic        i_seq,
    input  logic        i_restart,
    input  logic        i_active,
    input  logic        i_tready,
    output logic [7:0]  o_tdata,
    output logic        o_tlast,
    output logic        o_pkt_done
);

    logic [63:0]          r_payload;
    logic                 r_seq;
    logic [ABP_IDX_W-1:0] r_idx;
    logic                 w_hs;
    logic                 w_at_hdr;

    assign w_hs     = i_active && i_tready;
    assign w_at_hdr = (r_idx == ABP_IDX_W'(ABP_HDR_IDX));

    // Capture payload and sequence bit when a new packet is loaded.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_payload <= 64'h0;
            r_seq     <= 1'b0;
        end else if (i_load) begin
            r_payload <= i_value;
            r_seq     <= i_seq;
        end
    end

    // Byte index: rewinds on load/restart, advances on each non-final handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_idx <= '0;
        end else if (i_load || i_restart) begin
            r_idx <= '0;
        end else if (w_hs && !w_at_hdr) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // Byte mux: payload bytes low-first, then the header.
    always_comb begin
        o_tdata = r_payload[{r_idx[2:0], 3'b000} +: 8];
        if (w_at_hdr) begin
            o_tdata = abp_hdr_byte(r_seq);
        end
    end

    assign o_tlast    = i_active && w_at_hdr;
    assign o_pkt_done = w_hs && w_at_hdr;

endmodule

// File: rtl/abp_sender_transmitter.sv
// ABP sender-side transmitter: serializes a 64-bit value as a 9-byte packet on
// an 8-bit AXI-Stream master and retransmits on timeout until the matching
// ack arrives. Optional retry limit enabled by ABP_TX_RETRY_LIMIT_EN.
module abp_sender_transmitter
    import abp_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned MAX_RETRIES    = 8
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 send_valid,
    output logic                 send_ready,
    input  logic [63:0]          send_value,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic [7:0]           m_axis_tdata,
    input  logic                 ack_valid,
    input  logic                 ack_bit,
    output logic                 seq_bit,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] retx_count,
    output logic                 error
);

`ifdef ABP_TX_RETRY_LIMIT_EN
    localparam bit RetryLimitEn = 1'b1;
`else
    localparam bit RetryLimitEn = 1'b0;
`endif

    abp_tx_state_t        r_state;
    abp_tx_state_t        w_state_next;
    logic                 r_seq_bit;
    logic [CNT_WIDTH-1:0] r_timer;
    logic [CNT_WIDTH-1:0] r_retx;
    logic                 r_done;
    logic                 w_load;
    logic                 w_restart;
    logic                 w_pkt_done;
    logic                 w_ack_match;
    logic                 w_timeout;
    logic                 w_give_up;

    assign w_ack_match = (r_state == WAIT_ACK) && ack_valid && (ack_bit == r_seq_bit);
    assign w_timeout   = (r_state == WAIT_ACK) && (r_timer == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    assign w_give_up   = RetryLimitEn && w_timeout && (r_retx == CNT_WIDTH'(MAX_RETRIES));

    abp_tx_serializer u_serializer (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .i_load     (w_load),
        .i_value    (send_value),
        .i_seq      (r_seq_bit),
        .i_restart  (w_restart),
        .i_active   (m_axis_tvalid),
        .i_tready   (m_axis_tready),
        .o_tdata    (m_axis_tdata),
        .o_tlast    (m_axis_tlast),
        .o_pkt_done (w_pkt_done)
    );

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control strobes; a matching ack beats a same-cycle timeout.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_restart    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (send_valid) begin
                    w_load       = 1'b1;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                if (w_pkt_done) begin
                    w_state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (w_ack_match) begin
                    w_state_next = IDLE;
                end else if (w_give_up) begin
                    w_state_next = IDLE;
                end else if (w_timeout) begin
                    w_restart    = 1'b1;
                    w_state_next = SEND;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Timeout timer: cleared as the packet completes, counts while awaiting the ack.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_timer <= '0;
        end else if (w_pkt_done) begin
            r_timer <= '0;
        end else if (r_state == WAIT_ACK) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Retransmission counter, saturating at all-ones.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_retx <= '0;
        end else if (w_load) begin
            r_retx <= '0;
        end else if (w_restart && (r_retx != '1)) begin
            r_retx <= r_retx + 1'b1;
        end
    end

    // Sequence bit toggles and done pulses on the matching ack.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_seq_bit <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_ack_match;
            if (w_ack_match) begin
                r_seq_bit <= ~r_seq_bit;
            end
        end
    end

`ifdef ABP_TX_RETRY_LIMIT_EN
    logic r_error;

    // Sticky error on giving up; a new acceptance clears it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_error <= 1'b0;
        end else if (w_load) begin
            r_error <= 1'b0;
        end else if (w_give_up) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    assign send_ready    = (r_state == IDLE);
    assign busy          = (r_state != IDLE);
    assign m_axis_tvalid = (r_state == SEND);
    assign seq_bit       = r_seq_bit;
    assign done          = r_done;
    assign retx_count    = r_retx;

endmodule

// File: tb/tb_abp_sender_transmitter.sv
// Randomized bench for abp_sender_transmitter against a transaction-level
// model: expected bytes come from the packet layout, expected seq/retx/done
// from the protocol rules. Inputs change and outputs are sampled on negedges.
module tb_abp_sender_transmitter;

    localparam int unsigned T  = 16;
    localparam int unsigned CW = 8;
    localparam int unsigned MR = 2;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          send_valid = 1'b0;
    logic          send_ready;
    logic [63:0]   send_value = 64'h0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic [7:0]    m_axis_tdata;
    logic          ack_valid = 1'b0;
    logic          ack_bit = 1'b0;
    logic          seq_bit;
    logic          busy;
    logic          done;
    logic [CW-1:0] retx_count;
    logic          error;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        seq_exp  = 1'b0;
    int unsigned retx_exp = 0;

    always #5 aclk = ~aclk;

    abp_sender_transmitter #(
        .TIMEOUT_CYCLES (T),
        .CNT_WIDTH      (CW),
        .MAX_RETRIES    (MR)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .send_valid    (send_valid),
        .send_ready    (send_ready),
        .send_value    (send_value),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .ack_valid     (ack_valid),
        .ack_bit       (ack_bit),
        .seq_bit       (seq_bit),
        .busy          (busy),
        .done          (done),
        .retx_count    (retx_count),
        .error         (error)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Byte k of a packet: payload little-endian, then header with the seq bit.
    function automatic logic [7:0] exp_byte(input logic [63:0] v, input logic s, input int k);
        if (k == 8) return {7'b0, s};
        return 8'((v >> (8 * k)) & 64'hFF);
    endfunction

    task automatic accept(input logic [63:0] v);
        int g = 0;
        while (!send_ready && g < 50) begin
            @(negedge aclk);
            g++;
        end
        check_eq("ready_idle", send_ready, 1);
        send_valid = 1'b1;
        send_value = v;
        @(negedge aclk);
        send_valid = 1'b0;
        send_value = {$urandom, $urandom};
        check_eq("tvalid_rise", m_axis_tvalid, 1);
        check_eq("ready_low", send_ready, 0);
        check_eq("busy_send", busy, 1);
        check_eq("retx_clear", retx_count, 0);
        check_eq("error_clear", error, 0);
        retx_exp = 0;
    endtask

    // mode 0: tready held high, 1: random, 2: pattern 1,0,0,1,0,0...
    task automatic collect_pkt(input logic [63:0] v, input int mode);
        int k = 0;
        int cyc = 0;
        check_eq("seq_hold", seq_bit, seq_exp);
        while (k < 9 && cyc < 200) begin
            check_eq("tvalid_hold", m_axis_tvalid, 1);
            if (!m_axis_tvalid) break;
            check_eq("tdata", m_axis_tdata, exp_byte(v, seq_exp, k));
            check_eq("tlast", m_axis_tlast, (k == 8));
            check_eq("ready_send", send_ready, 0);
            case (mode)
                0:       m_axis_tready = 1'b1;
                2:       m_axis_tready = (cyc % 3 == 0);
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            // Requests and acks during SEND must be ignored.
            send_valid = 1'($urandom_range(0, 1));
            send_value = {$urandom, $urandom};
            ack_valid  = 1'($urandom_range(0, 1));
            ack_bit    = 1'($urandom_range(0, 1));
            if (m_axis_tready) k++;
            cyc++;
            @(negedge aclk);
        end
        m_axis_tready = 1'($urandom_range(0, 1));
        send_valid    = 1'b0;
        ack_valid     = 1'b0;
        if (k < 9) check_eq("pkt_complete", k, 9);
        if (mode == 0) check_eq("pkt_cycles", cyc, 9);
    endtask

    // No matching ack for the whole timeout window; only wrong-bit acks.
    task automatic timeout_round();
        for (int w = 0; w < int'(T); w++) begin
            check_eq("wait_tvalid", m_axis_tvalid, 0);
            check_eq("wait_busy", busy, 1);
            ack_valid = 1'($urandom_range(0, 1));
            ack_bit   = ~seq_exp;
            @(negedge aclk);
        end
        ack_valid = 1'b0;
        check_eq("retx_tvalid", m_axis_tvalid, 1);
        retx_exp++;
        check_eq("retx_count", retx_count, retx_exp);
    endtask

    // Matching ack on wait cycle d (d == T-1 collides with the timeout).
    task automatic ack_round(input int d);
        for (int w = 0; w <= d; w++) begin
            check_eq("wait_tvalid", m_axis_tvalid, 0);
            if (w == d) begin
                ack_valid = 1'b1;
                ack_bit   = seq_exp;
            end else begin
                ack_valid = 1'($urandom_range(0, 1));
                ack_bit   = ~seq_exp;
            end
            @(negedge aclk);
        end
        ack_valid = 1'b0;
        seq_exp   = ~seq_exp;
        check_eq("done_pulse", done, 1);
        check_eq("seq_toggle", seq_bit, seq_exp);
        check_eq("ready_back", send_ready, 1);
        check_eq("busy_idle", busy, 0);
        check_eq("no_retx_tvalid", m_axis_tvalid, 0);
        check_eq("retx_keep", retx_count, retx_exp);
        // Acks in IDLE are ignored.
        ack_valid = 1'($urandom_range(0, 1));
        ack_bit   = 1'($urandom_range(0, 1));
        @(negedge aclk);
        ack_valid = 1'b0;
        check_eq("done_one_cycle", done, 0);
        check_eq("seq_idle_ack", seq_bit, seq_exp);
    endtask

    task automatic transact(input logic [63:0] v, input int mode, input int nto, input int d);
        accept(v);
        collect_pkt(v, mode);
        for (int i = 0; i < nto; i++) begin
            timeout_round();
            collect_pkt(v, mode);
        end
        ack_round(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v;
        #12;
        check_eq("rst_tvalid", m_axis_tvalid, 0);
        check_eq("rst_tlast", m_axis_tlast, 0);
        check_eq("rst_tdata", m_axis_tdata, 0);
        check_eq("rst_seq", seq_bit, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_retx", retx_count, 0);
        check_eq("rst_error", error, 0);
        check_eq("rst_ready", send_ready, 1);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        transact(64'h0123_4567_89AB_CDEF, 0, 0, 3);
        transact(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
        transact({$urandom, $urandom}, 2, 0, 5);
        transact({$urandom, $urandom}, 1, 1, 4);
        transact({$urandom, $urandom}, 1, 1, T - 1);
        transact({$urandom, $urandom}, 0, 0, T - 1);
        for (int i = 0; i < 10; i++) begin
            transact({$urandom, $urandom}, 1, $urandom_range(0, 2), $urandom_range(0, T - 1));
        end
        if (seq_exp == 1'b0) transact({$urandom, $urandom}, 0, 0, 1);

        // Reset after four bytes have been handshaken.
        v = {$urandom, $urandom};
        accept(v);
        for (int k = 0; k < 4; k++) begin
            check_eq("pre_rst_tdata", m_axis_tdata, exp_byte(v, seq_exp, k));
            m_axis_tready = 1'b1;
            @(negedge aclk);
        end
        m_axis_tready = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        check_eq("mid_rst_tvalid", m_axis_tvalid, 0);
        check_eq("mid_rst_tlast", m_axis_tlast, 0);
        check_eq("mid_rst_seq", seq_bit, 0);
        check_eq("mid_rst_ready", send_ready, 1);
        check_eq("mid_rst_busy", busy, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        seq_exp = 1'b0;
        @(negedge aclk);
        check_eq("post_rst_ready", send_ready, 1);
        check_eq("post_rst_seq", seq_bit, 0);
        check_eq("post_rst_tvalid", m_axis_tvalid, 0);

`ifdef ABP_TX_RETRY_LIMIT_EN
        // No ack at all: initial send plus MR retransmissions, then give up.
        v = {$urandom, $urandom};
        accept(v);
        collect_pkt(v, 1);
        for (int i = 0; i < int'(MR); i++) begin
            timeout_round();
            collect_pkt(v, 1);
        end
        for (int w = 0; w < int'(T); w++) begin
            check_eq("lim_wait_tvalid", m_axis_tvalid, 0);
            @(negedge aclk);
        end
        check_eq("lim_error", error, 1);
        check_eq("lim_ready", send_ready, 1);
        check_eq("lim_done", done, 0);
        check_eq("lim_seq", seq_bit, seq_exp);
        check_eq("lim_tvalid", m_axis_tvalid, 0);
        @(negedge aclk);
        check_eq("lim_error_sticky", error, 1);
`endif

        transact({$urandom, $urandom}, 1, 0, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
